// File: rtl/haar_pkg.sv
// Shared types and constants for the Haar feature-sum datapath.
// FSM encoding, corner signs, point-index fields and width helpers.
`timescale 1ns/1ps
package haar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } haar_st_e;

  // One bit per corner, 1 = positive contribution.
  localparam logic [3:0] CORNER_POS = 4'b0101;
  localparam logic [1:0] CORNER_FIRST = 2'd0;
  localparam logic [1:0] CORNER_LAST = 2'd3;

  localparam int PT_CORN_LO = 0;
  localparam int PT_CORN_HI = 1;
  localparam int PT_RECT_LO = 2;
  localparam int PT_RECT_HI = 3;

  function automatic int rect_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int prod_w(input int dw, input int ww);
    return dw + 2 + ww;
  endfunction

  function automatic int acc_w(input int dw, input int ww);
    return dw + ww + 4;
  endfunction

endpackage

// File: rtl/haar_sat_conv.sv
// Narrows the feature accumulator to the output width.
// HAAR_SUM_SAT_EN selects saturation; otherwise two's-complement wrap.
`timescale 1ns/1ps
module haar_sat_conv #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  i_acc,
  output logic signed [OUT_W-1:0] o_sum
);

  generate
    if (IN_W > OUT_W) begin : g_narrow
`ifdef HAAR_SUM_SAT_EN
      logic [IN_W-OUT_W:0] w_hi;
      logic                w_ovf;

      assign w_hi  = i_acc[IN_W-1:OUT_W-1];
      assign w_ovf = ~((&w_hi) | ~(|w_hi));

      always_comb begin
        o_sum = i_acc[OUT_W-1:0];
        if (w_ovf) begin
          if (i_acc[IN_W-1]) begin
            o_sum = {1'b1, {(OUT_W-1){1'b0}}};
          end else begin
            o_sum = {1'b0, {(OUT_W-1){1'b1}}};
          end
        end
      end
`else
      logic w_unused_hi;

      assign w_unused_hi = ^i_acc[IN_W-1:OUT_W];
      assign o_sum       = i_acc[OUT_W-1:0];
`endif
    end else if (IN_W == OUT_W) begin : g_same
      assign o_sum = i_acc;
    end else begin : g_wide
      assign o_sum = {{(OUT_W-IN_W){i_acc[IN_W-1]}}, i_acc};
    end
  endgenerate

endmodule

// File: rtl/haar_feature_sum.sv
// Weighted Haar rectangle-sum evaluator with point-order checking.
// Build option HAAR_SUM_SAT_EN: saturating output conversion.
`timescale 1ns/1ps
module haar_feature_sum
  import haar_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_RECT = 3,
  parameter int WEIGHT_W = 4,
  parameter int OUT_W    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ii_val_i,
  output logic                       ii_ready_o,
  input  logic [DATA_W-1:0]          ii_data_i,
  input  logic [3:0]                 num_point_i,
  input  logic                       ii_last_i,
  input  logic signed [WEIGHT_W-1:0] weight_i,
  output logic signed [OUT_W-1:0]    sum_o,
  output logic                       sum_val_o,
  input  logic                       sum_ready_i,
  output logic                       err_o
);

  localparam int RECT_W = rect_w(DATA_W);
  localparam int PROD_W = prod_w(DATA_W, WEIGHT_W);
  localparam int ACC_W  = acc_w(DATA_W, WEIGHT_W);

  haar_st_e r_state;
  haar_st_e w_state_nxt;

  logic [4:0]                 r_exp_idx;
  logic signed [RECT_W-1:0]   r_rect;
  logic signed [WEIGHT_W-1:0] r_weight;
  logic signed [PROD_W-1:0]   r_prod;
  logic                       r_prod_vld;
  logic signed [ACC_W-1:0]    r_feat;
  logic signed [OUT_W-1:0]    r_sum;
  logic                       r_err;
  logic                       r_drain;

  logic [1:0]                 w_corner;
  logic [1:0]                 w_rect_idx;
  logic                       w_acc;
  logic                       w_err;
  logic                       w_good;
  logic                       w_bad;
  logic                       w_start;
  logic signed [RECT_W-1:0]   w_samp;
  logic signed [RECT_W-1:0]   w_rect_base;
  logic signed [RECT_W-1:0]   w_rect_nxt;
  logic signed [PROD_W-1:0]   w_rect_ext;
  logic signed [PROD_W-1:0]   w_wgt_ext;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [OUT_W-1:0]    w_conv;

  assign w_corner   = num_point_i[PT_CORN_HI:PT_CORN_LO];
  assign w_rect_idx = num_point_i[PT_RECT_HI:PT_RECT_LO];

  assign ii_ready_o = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  assign w_acc      = ii_val_i && ii_ready_o;

  assign w_err = ({1'b0, num_point_i} != r_exp_idx)
               | (int'(w_rect_idx) >= MAX_RECT)
               | (ii_last_i & (w_corner != CORNER_LAST));

  assign w_good  = w_acc & ~w_err;
  assign w_bad   = w_acc & w_err;
  assign w_start = w_good & (r_exp_idx == 5'd0);

  // Corner 0 restarts the rectangle; signs come from CORNER_POS.
  assign w_samp      = $signed({2'b00, ii_data_i});
  assign w_rect_base = (w_corner == CORNER_FIRST) ? '0 : r_rect;
  assign w_rect_nxt  = CORNER_POS[w_corner] ? (w_rect_base + w_samp)
                                            : (w_rect_base - w_samp);

  assign w_rect_ext = {{WEIGHT_W{w_rect_nxt[RECT_W-1]}}, w_rect_nxt};
  assign w_wgt_ext  = {{(PROD_W-WEIGHT_W){r_weight[WEIGHT_W-1]}},
                       r_weight};
  assign w_prod     = w_rect_ext * w_wgt_ext;
  assign w_prod_ext = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};

  haar_sat_conv #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_conv (
    .i_acc (r_feat),
    .o_sum (w_conv)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_bad) begin
          w_state_nxt = ST_IDLE;
        end else if (w_good) begin
          w_state_nxt = ii_last_i ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (r_drain) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (sum_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_exp_idx  <= '0;
      r_rect     <= '0;
      r_weight   <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_feat     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= w_bad;
      r_prod_vld <= w_good && (w_corner == CORNER_LAST);
      if (w_bad) begin
        r_exp_idx <= '0;
        r_rect    <= '0;
        r_weight  <= '0;
        r_prod    <= '0;
      end else if (w_good) begin
        r_exp_idx <= ii_last_i ? 5'd0 : (r_exp_idx + 5'd1);
        r_rect    <= w_rect_nxt;
        if (w_corner == CORNER_FIRST) begin
          r_weight <= weight_i;
        end
        if (w_corner == CORNER_LAST) begin
          r_prod <= w_prod;
        end
      end
      // A pending product never coincides with a feature start.
      if (w_bad || w_start) begin
        r_feat <= '0;
      end else if (r_prod_vld) begin
        r_feat <= r_feat + w_prod_ext;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sum <= '0;
    end else if ((r_state == ST_DRAIN) && r_drain) begin
      r_sum <= w_conv;
    end
  end

  assign sum_o     = r_sum;
  assign sum_val_o = (r_state == ST_HOLD);
  assign err_o     = r_err;

endmodule

// File: tb/tb_haar_feature_sum.sv
// Randomised self-checking bench for haar_feature_sum.
// Reference sums come from plain rectangle arithmetic.
`timescale 1ns/1ps
module tb_haar_feature_sum;

  localparam int DW = 32;
  localparam int MR = 3;
  localparam int WW = 4;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 ii_val_i;
  logic                 ii_ready_o;
  logic [DW-1:0]        ii_data_i;
  logic [3:0]           num_point_i;
  logic                 ii_last_i;
  logic signed [WW-1:0] weight_i;
  logic signed [OW-1:0] sum_o;
  logic                 sum_val_o;
  logic                 sum_ready_i;
  logic                 err_o;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] pts [12];
  int          wts [3];

  always #5 clk = ~clk;

  haar_feature_sum #(
    .DATA_W   (DW),
    .MAX_RECT (MR),
    .WEIGHT_W (WW),
    .OUT_W    (OW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ii_val_i    (ii_val_i),
    .ii_ready_o  (ii_ready_o),
    .ii_data_i   (ii_data_i),
    .num_point_i (num_point_i),
    .ii_last_i   (ii_last_i),
    .weight_i    (weight_i),
    .sum_o       (sum_o),
    .sum_val_o   (sum_val_o),
    .sum_ready_i (sum_ready_i),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic longint conv(input longint v);
`ifdef HAAR_SUM_SAT_EN
    longint lim;
    lim = longint'(1) << (OW - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    longint lim;
    longint m;
    lim = longint'(1) << (OW - 1);
    m = v % (2 * lim);
    if (m < 0) m = m + 2 * lim;
    if (m >= lim) m = m - 2 * lim;
    return m;
`endif
  endfunction

  function automatic longint model(input int nr);
    longint s;
    longint rv;
    s = 0;
    for (int r = 0; r < nr; r++) begin
      rv = longint'(pts[4*r]) - longint'(pts[4*r+1])
         + longint'(pts[4*r+2]) - longint'(pts[4*r+3]);
      s = s + longint'(wts[r]) * rv;
    end
    return conv(s);
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input int idx, input logic [31:0] d,
                      input bit last, input int w);
    bit ok;
    int n;
    ii_val_i    = 1'b1;
    num_point_i = 4'(idx);
    ii_data_i   = d;
    ii_last_i   = last;
    weight_i    = WW'(w);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (ii_ready_o) ok = 1'b1;
      @(posedge clk);
      n++;
    end
    #1;
    ii_val_i  = 1'b0;
    ii_last_i = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic feature(input int nr, input int hold);
    longint e;
    e = model(nr);
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < 4; c++) begin
        send(4*r + c, pts[4*r+c], (r == nr-1) && (c == 3), wts[r]);
      end
    end
    check("drain1_val", sum_val_o, 0);
    check("drain1_ready", ii_ready_o, 0);
    check("drain1_err", err_o, 0);
    @(posedge clk); #1;
    check("drain2_val", sum_val_o, 0);
    @(posedge clk); #1;
    check("lat_val", sum_val_o, 1);
    check("sum", sum_o, e);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_val", sum_val_o, 1);
      check("hold_sum", sum_o, e);
      check("hold_ready", ii_ready_o, 0);
    end
    sum_ready_i = 1'b1;
    @(posedge clk); #1;
    sum_ready_i = 1'b0;
    check("rel_val", sum_val_o, 0);
    check("rel_ready", ii_ready_o, 1);
  endtask

  task automatic good_pt(input int idx);
    send(idx, $urandom_range(0, 5000), 1'b0, 1);
    check("err_early", err_o, 0);
  endtask

  task automatic bad_pt(input int idx, input bit last);
    send(idx, $urandom, last, 1);
    check("err_pulse", err_o, 1);
    check("err_noval", sum_val_o, 0);
    check("err_ready", ii_ready_o, 1);
    @(posedge clk); #1;
    check("err_once", err_o, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("err_nosum", sum_val_o, 0);
    end
  endtask

  task automatic err_feat(input int kind);
    case (kind)
      0: begin
        good_pt(0); good_pt(1); bad_pt(3, 1'b0);
      end
      1: begin
        for (int i = 0; i < 12; i++) good_pt(i);
        bad_pt(12, 1'b0);
      end
      2: begin
        good_pt(0); bad_pt(1, 1'b1);
      end
      default: begin
        good_pt(0); good_pt(1); bad_pt(0, 1'b0);
        bad_pt(1, 1'b0);
      end
    endcase
  endtask

  task automatic fill(input int nr);
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < 4*nr; i++) begin
      case (mode)
        0: pts[i] = $urandom_range(0, 1000);
        1: pts[i] = $urandom;
        default: pts[i] = $urandom_range(0, 50000);
      endcase
    end
    for (int r = 0; r < nr; r++) wts[r] = $urandom_range(0, 15) - 8;
  endtask

  task automatic set_rect(input int r, input int a, input int b,
                          input int c, input int d, input int w);
    pts[4*r]   = 32'(a);
    pts[4*r+1] = 32'(b);
    pts[4*r+2] = 32'(c);
    pts[4*r+3] = 32'(d);
    wts[r]     = w;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, ii_ready_o, 1);
    check({tag, "_val"}, sum_val_o, 0);
    check({tag, "_sum"}, sum_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int nr;
    rst_i       = 1'b1;
    ii_val_i    = 1'b0;
    ii_data_i   = '0;
    num_point_i = '0;
    ii_last_i   = 1'b0;
    weight_i    = '0;
    sum_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk) rst_i = 1'b0;
    @(posedge clk); #1;

    set_rect(0, 100, 40, 10, 30, 1);
    feature(1, 0);
    check("t1_const", sum_o, 40);

    set_rect(0, 100, 40, 10, 30, -1);
    set_rect(1, 50, 20, 5, 15, 3);
    feature(2, 0);
    check("t2_const", sum_o, 20);

    fill(2);
    feature(2, 5);

    for (int k = 0; k < 4; k++) begin
      err_feat(k);
      fill(3);
      feature(3, 0);
    end

    set_rect(0, 40000, 0, 0, 0, 1);
    feature(1, 1);
    set_rect(0, 0, 40000, 0, 0, 1);
    feature(1, 0);
    set_rect(0, 32767, 0, 0, 0, 1);
    feature(1, 0);
    set_rect(0, 16384, 0, 0, 0, 2);
    feature(1, 0);

    set_rect(0, 100, 40, 10, 30, 1);
    send(0, pts[0], 1'b0, 1);
    send(1, pts[1], 1'b0, 1);
    send(2, pts[2], 1'b0, 1);
    send(3, pts[3], 1'b1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_val", sum_val_o, 1);
    #2 rst_i = 1'b1;
    #1 check_reset("rst_hold");
    @(negedge clk) rst_i = 1'b0;
    @(posedge clk); #1;

    good_pt(0);
    good_pt(1);
    #2 rst_i = 1'b1;
    #1 check_reset("rst_accum");
    @(negedge clk) rst_i = 1'b0;
    @(posedge clk); #1;
    fill(2);
    feature(2, 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        err_feat($urandom_range(0, 3));
      end else begin
        nr = $urandom_range(1, MR);
        fill(nr);
        feature(nr, $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
